// File: rtl/spi_frame_rx.sv
// Receives MSB-first debug frames over a Mode-0 SPI link and snapshots the
// register/PC/stage fields into the clk domain.
module spi_frame_rx #(
    parameter int FRAME_BITS  = 40,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic [7:0] a_val,
    output logic [7:0] b_val,
    output logic [7:0] acc_val,
    output logic [3:0] pc_val,
    output logic [2:0] state_val,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] BITS_FULL  = CW'(FRAME_BITS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, RECV, ABORT} state_t;

    logic [1:0] sclk_sync, mosi_sync, cs_sync;
    logic       sclk_prev, cs_prev;
    logic [1:0] settle;
    logic       sclk_rise, cs_fall, cs_rise, mosi_bit, cs_high;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [CW-1:0]           bit_cnt, bit_next;
    logic [TW-1:0]           timer;
    logic                    load_pend;

    // Edge pulses are held off until the synchronizers carry real pin samples,
    // so a cs_n held low across reset never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_sync   <= 2'b11;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            settle    <= 2'd0;
            sclk_rise <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            mosi_bit  <= 1'b0;
            cs_high   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_sync   <= {cs_sync[0], cs_n};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
            settle    <= (settle == 2'd3) ? settle : settle + 2'd1;
            sclk_rise <= (settle == 2'd3) & sclk_sync[1] & ~sclk_prev;
            cs_fall   <= (settle == 2'd3) & ~cs_sync[1] & cs_prev;
            cs_rise   <= (settle == 2'd3) & cs_sync[1] & ~cs_prev;
            mosi_bit  <= mosi_sync[1];
            cs_high   <= cs_sync[1];
        end
    end

    // A same-cycle sclk edge is counted before the completeness check.
    always_comb begin
        bit_next = bit_cnt;
        if (sclk_rise && bit_cnt != BITS_FULL)
            bit_next = bit_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            timer       <= '0;
            load_pend   <= 1'b0;
            a_val       <= 8'd0;
            b_val       <= 8'd0;
            acc_val     <= 8'd0;
            pc_val      <= 4'd0;
            state_val   <= 3'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            load_pend   <= 1'b0;

            if (load_pend) begin
                a_val       <= shreg[39:32];
                b_val       <= shreg[31:24];
                acc_val     <= shreg[23:16];
                pc_val      <= shreg[11:8];
                state_val   <= shreg[2:0];
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= RECV;
                        busy    <= 1'b1;
                        shreg   <= '0;
                        bit_cnt <= '0;
                        timer   <= '0;
                    end
                end
                RECV: begin
                    if (sclk_rise)
                        shreg <= {shreg[FRAME_BITS-2:0], mosi_bit};
                    bit_cnt <= bit_next;
                    if (cs_rise) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (bit_next == BITS_FULL)
                            load_pend <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        state     <= ABORT;
                        frame_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ABORT: begin
                    if (cs_high) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: directed vector table, random frames
// against a bit-queue reference model, and timeout / mid-frame reset sequences.
module tb_spi_frame_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic [7:0] a_val, b_val, acc_val, frame_cnt;
    logic [3:0] pc_val;
    logic [2:0] state_val;
    logic       frame_valid, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int nv = 0, ne = 0, overlap = 0;

    spi_frame_rx dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .a_val(a_val), .b_val(b_val), .acc_val(acc_val), .pc_val(pc_val),
        .state_val(state_val), .frame_valid(frame_valid), .frame_err(frame_err),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_valid) nv++;
            if (frame_err) ne++;
            if (frame_valid && frame_err) overlap++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          n;
        logic [63:0] bits;
        int          h;
        logic        exp_valid;
        logic [7:0]  a, b, acc;
        logic [3:0]  pc;
        logic [2:0]  st;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[8];

    logic [30:0] e_fields = '0;
    logic [7:0]  e_cnt = 8'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input int h);
        @(negedge clk);
        cs_n = 1'b0;
        cyc(h);
    endtask

    task automatic send_bit(input logic b, input int h);
        mosi = b;
        cyc(h);
        sclk = 1'b1;
        cyc(h);
        sclk = 1'b0;
    endtask

    // lat = number of clk edges after the first edge that samples cs_n high
    task automatic end_frame(input int h, output int lat);
        cyc(h);
        chk("busy_in_frame", busy, 1);
        cs_n = 1'b1;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid && lat < 0) lat = k;
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] v, input int n, input int h, output int lat);
        start_frame(h);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], h);
        end_frame(h, lat);
    endtask

    function automatic logic [30:0] fields_of(input logic [39:0] f);
        return {f[39:32], f[31:24], f[23:16], f[11:8], f[2:0]};
    endfunction

    function automatic logic [30:0] dut_fields();
        return {a_val, b_val, acc_val, pc_val, state_val};
    endfunction

    initial begin
        int lat, b_nv, b_ne, n, ek;
        logic [63:0] v;
        logic [39:0] f;
        bit q[$];

        tbl[0] = '{40, 64'h0A040E0305,     200, 1'b1, 8'h0A, 8'h04, 8'h0E, 4'h3, 3'h5, 8'd1};
        tbl[1] = '{20, 64'h12345,          2,   1'b0, 8'h0A, 8'h04, 8'h0E, 4'h3, 3'h5, 8'd1};
        tbl[2] = '{41, 64'h10A040E0305,    2,   1'b1, 8'h0A, 8'h04, 8'h0E, 4'h3, 3'h5, 8'd2};
        tbl[3] = '{40, 64'hFFFFFFFFFF,     2,   1'b1, 8'hFF, 8'hFF, 8'hFF, 4'hF, 3'h7, 8'd3};
        tbl[4] = '{39, 64'h0,              3,   1'b0, 8'hFF, 8'hFF, 8'hFF, 4'hF, 3'h7, 8'd3};
        tbl[5] = '{40, 64'h5AC33CF8F9,     2,   1'b1, 8'h5A, 8'hC3, 8'h3C, 4'h8, 3'h1, 8'd4};
        tbl[6] = '{0,  64'h0,              2,   1'b0, 8'h5A, 8'hC3, 8'h3C, 4'h8, 3'h1, 8'd4};
        tbl[7] = '{56, 64'hDEAD112233A456, 3,   1'b1, 8'h11, 8'h22, 8'h33, 4'h4, 3'h6, 8'd5};

        // reset state
        #2;
        chk("rst_fields", dut_fields(), 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_flags", {frame_valid, frame_err, busy}, 0);
        cyc(4);
        reset_n = 1'b1;
        cyc(6);

        // directed vector table
        for (int i = 0; i < 8; i++) begin
            b_nv = nv;
            b_ne = ne;
            send_frame(tbl[i].bits, tbl[i].n, tbl[i].h, lat);
            chk("tbl_valid_pulses", nv - b_nv, tbl[i].exp_valid ? 1 : 0);
            chk("tbl_err_pulses", ne - b_ne, tbl[i].exp_valid ? 0 : 1);
            chk("tbl_fields", dut_fields(),
                {tbl[i].a, tbl[i].b, tbl[i].acc, tbl[i].pc, tbl[i].st});
            chk("tbl_cnt", frame_cnt, tbl[i].cnt);
            chk("tbl_busy_after", busy, 0);
            if (tbl[i].exp_valid) chk("tbl_latency", lat, 4);
            e_fields = {tbl[i].a, tbl[i].b, tbl[i].acc, tbl[i].pc, tbl[i].st};
            e_cnt = tbl[i].cnt;
        end

        // random short frames: discarded, nothing changes
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(39, 1);
            v = {$urandom(), $urandom()};
            b_nv = nv;
            b_ne = ne;
            send_frame(v, n, 2, lat);
            chk("short_err_pulses", ne - b_ne, 1);
            chk("short_valid_pulses", nv - b_nv, 0);
            chk("short_fields", dut_fields(), e_fields);
            chk("short_cnt", frame_cnt, e_cnt);
        end

        // 256 random valid frames; the counter wraps back to its start value
        b_nv = nv;
        b_ne = ne;
        for (int i = 0; i < 256; i++) begin
            n = $urandom_range(47, 40);
            v = {$urandom(), $urandom()};
            q.delete();
            start_frame(1);
            for (int j = n - 1; j >= 0; j--) begin
                q.push_back(v[j]);
                send_bit(v[j], 1);
            end
            end_frame(1, lat);
            for (int j = 0; j < 40; j++) f[39-j] = q[q.size() - 40 + j];
            e_fields = fields_of(f);
            e_cnt = e_cnt + 8'd1;
            chk("rand_fields", dut_fields(), e_fields);
        end
        chk("rand_valid_pulses", nv - b_nv, 256);
        chk("rand_err_pulses", ne - b_ne, 0);
        chk("rand_cnt_wrap", frame_cnt, e_cnt);

        // timeout: 10 bits then sclk parked for 5000 cycles
        b_nv = nv;
        b_ne = ne;
        start_frame(2);
        for (int i = 0; i < 9; i++) send_bit(i[0], 2);
        mosi = 1'b1;
        cyc(2);
        sclk = 1'b1;
        ek = -1;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) sclk = 1'b0;
            if (frame_err && ek < 0) ek = k;
        end
        checks++;
        if (ek < 4096 || ek > 4104) begin
            failures++;
            $display("FAIL timeout_cycle: got %0d expected 4096..4104", ek);
        end
        chk("timeout_err_pulses", ne - b_ne, 1);
        chk("timeout_busy_held", busy, 1);
        @(negedge clk);
        cs_n = 1'b1;
        cyc(8);
        chk("timeout_busy_released", busy, 0);
        chk("timeout_err_after_cs", ne - b_ne, 1);
        chk("timeout_valid_pulses", nv - b_nv, 0);
        chk("timeout_fields", dut_fields(), e_fields);

        // reset in the middle of a frame
        start_frame(2);
        for (int i = 0; i < 25; i++) send_bit(1'b1, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_fields", dut_fields(), 0);
        chk("midrst_cnt", frame_cnt, 0);
        chk("midrst_flags", {frame_valid, frame_err, busy}, 0);
        cyc(3);
        reset_n = 1'b1;
        b_nv = nv;
        b_ne = ne;
        for (int i = 0; i < 15; i++) send_bit(1'b1, 2);
        chk("midrst_no_resume", busy, 0);
        cs_n = 1'b1;
        cyc(12);
        chk("midrst_no_pulses", (nv - b_nv) + (ne - b_ne), 0);
        send_frame(64'hFF01800F07, 40, 2, lat);
        chk("postrst_fields", dut_fields(), {8'hFF, 8'h01, 8'h80, 4'hF, 3'h7});
        chk("postrst_cnt", frame_cnt, 1);
        chk("postrst_latency", lat, 4);
        chk("postrst_valid_pulses", nv - b_nv, 1);

        chk("valid_err_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
